mux2_rr_arbiter: RTL

//  Round-robin arbiter and sequencer for a shared 2:1 datapath mux. Two requesters (a, b) offer

---
 rtl/mux2_arb_pkg.sv | 13 +
 rtl/mux2to1_wide.sv | 15 +
 rtl/mux2_rr_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-input round-robin mux arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2to1_wide.sv
// Purely combinational W-bit 2:1 multiplexer.
module mux2to1_wide #(
    parameter int W = 9
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out
);

    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter for two valid/ready streams feeding one registered output.
// The mux select is locked for a whole packet; an optional beat guard forces release.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    input  logic         a_last,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    input  logic         b_last,
    output logic         b_ready,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    output logic         y_last,
    output logic         y_src,
    input  logic         y_ready,
    output logic         sel,
    output logic         busy,
    output logic         trunc
);

    localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             trunc_q, trunc_d;
    logic [W:0]       mux_out;
    logic             accept;
    logic             beat_last;

    mux2to1_wide #(
        .W(W + 1)
    ) u_mux (
        .in0 ({a_last, a_data}),
        .in1 ({b_last, b_data}),
        .sel (sel_q),
        .out (mux_out)
    );

    // Ready only while the output slot is free or draining this cycle.
    always_comb begin
        a_ready   = (state_q == GNT_A) && (!y_valid || y_ready);
        b_ready   = (state_q == GNT_B) && (!y_valid || y_ready);
        accept    = (a_valid && a_ready) || (b_valid && b_ready);
        beat_last = mux_out[W];
        busy      = (state_q != IDLE);
        sel       = sel_q;
        trunc     = trunc_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        trunc_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ptr holds the last served source; on a tie the other one wins.
                if (a_valid && (!b_valid || ptr_q)) begin
                    state_d = GNT_A;
                    ptr_d   = SEL_A;
                    sel_d   = SEL_A;
                end else if (b_valid) begin
                    state_d = GNT_B;
                    ptr_d   = SEL_B;
                    sel_d   = SEL_B;
                end
            end
            GNT_A, GNT_B: begin
                if (accept) begin
                    if (beat_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (MAX_BEATS != 0 && cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        trunc_d = 1'b1;
                    end else if (MAX_BEATS != 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
            sel_q   <= SEL_A;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            trunc_q <= trunc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
            y_src   <= 1'b0;
        end else if (accept) begin
            y_valid <= 1'b1;
            y_data  <= mux_out[W-1:0];
            y_last  <= mux_out[W];
            y_src   <= sel_q;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule
